// File: rtl/hazard_ctrl.sv
// Hazard/bubble controller: load-use stall insertion, taken-branch squash,
// and saturating stall/flush event counters for performance debug.
module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                 REM_W    = $clog2(LOAD_STALL + 1);
  localparam logic [REM_W-1:0]   REM_INIT = REM_W'(LOAD_STALL - 1);
  localparam logic [REM_W-1:0]   REM_ONE  = REM_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t           state, state_next;
  logic [REM_W-1:0] remain, remain_next;
  logic             hazard;

  assign hazard = idex_memread && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      remain <= '0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
    end
  end

  // Multi-cycle bubbles only exist when LOAD_STALL > 1; the hazard cycle
  // itself is the first bubble, STALL covers the remaining ones.
  always_comb begin
    state_next  = state;
    remain_next = remain;
    case (state)
      RUN: begin
        if (branch_taken) begin
          remain_next = '0;
        end else if (hazard && (LOAD_STALL > 1)) begin
          state_next  = STALL;
          remain_next = REM_INIT;
        end
      end
      STALL: begin
        if (branch_taken) begin
          state_next  = RUN;
          remain_next = '0;
        end else begin
          remain_next = remain - REM_ONE;
          if (remain == REM_ONE) begin
            state_next = RUN;
          end
        end
      end
      default: begin
        state_next  = RUN;
        remain_next = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if ((state == STALL) || hazard) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Event counters saturate instead of wrapping so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (exmem_flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (LOAD_STALL=1, LOAD_STALL=3,
// CNT_W=4) share one stimulus stream and are checked against a reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs2, idex_memread, branch_taken;

  logic pc_write [3];
  logic ifid_write [3];
  logic ifid_flush [3];
  logic idex_flush [3];
  logic exmem_flush [3];
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [3:0]  sc_c, fc_c;

  typedef struct {
    logic [4:0] ctl;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  int m_ls  [3] = '{1, 3, 1};
  int m_max [3] = '{65535, 65535, 15};
  int m_left[3] = '{0, 0, 0};
  int m_sc  [3] = '{0, 0, 0};
  int m_fc  [3] = '{0, 0, 0};
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
    .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u_ls3 (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
    .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
    .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .exmem_flush(exmem_flush[2]),
    .stall_count(sc_c), .flush_count(fc_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", tag, cycle, obs, exp);
    end
  endtask

  function automatic bit modelHazard();
    return idex_memread && (idex_rd != 5'd0) &&
           ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}.
  function automatic logic [4:0] modelCtl(input int i);
    if (reset)                               return 5'b11000;
    if (branch_taken)                        return 5'b11111;
    if ((m_left[i] > 0) || modelHazard())    return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic logic [31:0] obsSc(input int i);
    case (i)
      0:       return 32'(sc_a);
      1:       return 32'(sc_b);
      default: return 32'(sc_c);
    endcase
  endfunction

  function automatic logic [31:0] obsFc(input int i);
    case (i)
      0:       return 32'(fc_a);
      1:       return 32'(fc_b);
      default: return 32'(fc_c);
    endcase
  endfunction

  task automatic applyStimulus(input bit rst, input bit mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit use2, input bit br);
    exp_t e;
    reset         = rst;
    idex_memread  = mr;
    idex_rd       = rd;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
    ifid_uses_rs2 = use2;
    branch_taken  = br;
    for (int i = 0; i < 3; i++) begin
      e.ctl = modelCtl(i);
      e.sc  = m_valid ? m_sc[i] : -1;
      e.fc  = m_valid ? m_fc[i] : -1;
      sb.push_back(e);
    end
  endtask

  task automatic compareAll();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      checkOutput($sformatf("ctl[%0d]", i),
                  32'({pc_write[i], ifid_write[i], ifid_flush[i], idex_flush[i], exmem_flush[i]}),
                  32'(e.ctl));
      if (e.sc >= 0) begin
        checkOutput($sformatf("stall_count[%0d]", i), obsSc(i), e.sc);
        checkOutput($sformatf("flush_count[%0d]", i), obsFc(i), e.fc);
      end
    end
  endtask

  task automatic advanceModel();
    logic [4:0] ctl;
    bit         hz;
    hz = modelHazard();
    for (int i = 0; i < 3; i++) begin
      ctl = modelCtl(i);
      if (reset) begin
        m_left[i] = 0;
        m_sc[i]   = 0;
        m_fc[i]   = 0;
      end else begin
        if (!ctl[4] && (m_sc[i] < m_max[i])) m_sc[i]++;
        if (ctl[0] && (m_fc[i] < m_max[i]))  m_fc[i]++;
        if (branch_taken)     m_left[i] = 0;
        else if (m_left[i] > 0) m_left[i]--;
        else if (hz)          m_left[i] = m_ls[i] - 1;
      end
    end
    if (reset) m_valid = 1'b1;
  endtask

  task automatic stepCycle(input bit rst, input bit mr, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input bit use2, input bit br);
    applyStimulus(rst, mr, rd, rs1, rs2, use2, br);
    @(negedge clk);
    compareAll();
    @(posedge clk);
    advanceModel();
    cycle++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) stepCycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; idex_memread = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    ifid_uses_rs2 = 1'b0; branch_taken = 1'b0;
    #1;
    stepCycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    stepCycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Single load-use hazard on rs1: one bubble for LOAD_STALL=1, three for LOAD_STALL=3.
    stepCycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    idle(4);
    checkOutput("t1_stall_ls1", 32'(sc_a), 1);
    checkOutput("t3_stall_ls3", 32'(sc_b), 3);

    // rs2 match only counts when the ID instruction reads rs2; x0 never stalls.
    stepCycle(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
    stepCycle(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0);
    idle(3);
    stepCycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    stepCycle(1'b0, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0);
    idle(1);

    // Branch together with hazard, then branch in the second stall cycle.
    stepCycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    idle(3);
    stepCycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    stepCycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Reset in the middle of a multi-cycle stall.
    stepCycle(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    stepCycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Long hazard run saturates the 4-bit counter, then a one-cycle reset clears it.
    for (int k = 0; k < 20; k++) stepCycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    checkOutput("sat_stall_cnt4", 32'(sc_c), 15);
    stepCycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_stall_cnt4", 32'(sc_c), 0);
    checkOutput("rst_flush_cnt4", 32'(fc_c), 0);
    idle(2);

    // Randomised traffic over a small register set to provoke frequent matches.
    for (int k = 0; k < 60; k++) begin
      stepCycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0));
    end
    idle(3);

    checkOutput("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
